// File: rtl/axburst_splitter.sv
// Splits a byte-addressed DMA request into AXI INCR bursts aligned to BL beats,
// tracking outstanding bursts, response errors and an optional idle timeout.
module axburst_splitter #(
   parameter int AXI_DW    = 128,
   parameter int AXI_AW    = 32,
   parameter int AXI_IW    = 8,
   parameter int AXI_LW    = 8,
   parameter int BL        = 16,
   parameter int MAX_OST   = 4,
   parameter int TO_CYCLES = 0,
   parameter int TXN_ID    = 1,
   localparam int L        = $clog2(AXI_DW / 8),
   localparam int OW       = $clog2(MAX_OST + 1)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cfg_dma_valid,
   output logic              cfg_dma_ready,
   input  logic [31:0]       cfg_dma_sa,
   input  logic [31:0]       cfg_dma_len,
   input  logic              dma_irq_w1c,
   output logic              dma_irq,
   output logic [3:0]        dma_err,
   output logic              dma_busy,
   output logic [OW-1:0]     ost_cnt,
   output logic [AXI_IW-1:0] axid,
   output logic [AXI_AW-1:0] axaddr,
   output logic [AXI_LW-1:0] axlen,
   output logic [2:0]        axsize,
   output logic [1:0]        axburst,
   output logic              axvalid,
   input  logic              axready,
   input  logic [AXI_IW-1:0] rsp_id,
   input  logic [1:0]        rsp_resp,
   input  logic              rsp_last,
   input  logic              rsp_valid,
   input  logic              rsp_ready
);

   typedef enum logic [1:0] {IDLE, BUSY, RESP, DONE} state_t;

   localparam logic [31:0]   AMASK   = 32'hFFFF_FFFF >> L;
   localparam logic [31:0]   BLM     = 32'(BL - 1);
   localparam logic [31:0]   TO_LAST = 32'(TO_CYCLES) - 32'd1;
   localparam logic [OW-1:0] OST_MAX = OW'(MAX_OST);

   state_t        state;
   logic [31:0]   addr_w, len_w, room, beats, to_cnt;
   logic          ax_hs, rsp_hs, rsp_ev, counting, to_hit;
   logic [OW-1:0] ost_nxt;

   // addr_w/len_w are in beat units; room is the distance to the next BL boundary
   assign room     = 32'(BL) - (addr_w & BLM);
   assign beats    = (len_w < room) ? len_w : room;

   assign cfg_dma_ready = (state == IDLE);
   assign dma_busy      = (state == BUSY) || (state == RESP);
   assign dma_irq       = (state == DONE);
   assign axvalid       = (state == BUSY) && (ost_cnt < OST_MAX);
   assign axaddr        = AXI_AW'(addr_w << L);
   assign axlen         = AXI_LW'(beats - 32'd1);
   assign axsize        = 3'(L);
   assign axburst       = 2'b01;
   assign axid          = AXI_IW'(TXN_ID);

   assign ax_hs    = axvalid && axready;
   assign rsp_hs   = rsp_valid && rsp_ready;
   assign rsp_ev   = rsp_hs && rsp_last;
   assign counting = dma_busy && !ax_hs && !rsp_ev;
   assign to_hit   = (TO_CYCLES != 0) && counting && (to_cnt == TO_LAST);

   always_comb begin
      ost_nxt = ost_cnt;
      if (ax_hs && !rsp_ev)
         ost_nxt = ost_cnt + OW'(1);
      else if (!ax_hs && rsp_ev && ost_cnt != '0)
         ost_nxt = ost_cnt - OW'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         addr_w  <= '0;
         len_w   <= '0;
         ost_cnt <= '0;
         to_cnt  <= '0;
         dma_err <= '0;
      end else begin
         ost_cnt <= ost_nxt;
         to_cnt  <= counting ? to_cnt + 32'd1 : 32'd0;
         if (rsp_hs) begin
            if (rsp_resp != 2'b00 && dma_err[1:0] == 2'b00)
               dma_err[1:0] <= rsp_resp;
            if (rsp_id != AXI_IW'(TXN_ID))
               dma_err[2] <= 1'b1;
         end
         case (state)
            IDLE: if (cfg_dma_valid) begin
               addr_w <= cfg_dma_sa >> L;
               len_w  <= cfg_dma_len >> L;
               state  <= ((cfg_dma_len >> L) != 32'd0) ? BUSY : DONE;
            end
            BUSY: if (ax_hs) begin
               addr_w <= (addr_w + beats) & AMASK;
               len_w  <= len_w - beats;
               if (len_w == beats)
                  state <= (ost_nxt == '0) ? DONE : RESP;
            end else if (to_hit) begin
               dma_err[3] <= 1'b1;
               state      <= DONE;
            end
            RESP: if (ost_nxt == '0) begin
               state <= DONE;
            end else if (to_hit) begin
               dma_err[3] <= 1'b1;
               state      <= DONE;
            end
            DONE: if (dma_irq_w1c) begin
               state   <= IDLE;
               dma_err <= '0;
               ost_cnt <= '0;
               to_cnt  <= '0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/axburst_splitter.md
AXBURST_SPLITTER -- requirements
Module: axburst_splitter

Interface
REQ-001 SHALL have parameter AXI_DW, default 128, data bus width in bits (power of 2, 32..1024); L = log2(AXI_DW/8).
REQ-002 SHALL have parameter AXI_AW, default 32, address width (<= 32).
REQ-003 SHALL have parameter AXI_IW, default 8, ID width; AXI_LW, default 8, axlen width.
REQ-004 SHALL have parameter BL, default 16, max beats per burst (power of 2, 1..256, BL*AXI_DW/8 <= 4096).
REQ-005 SHALL have parameter MAX_OST, default 4, max outstanding bursts (1..64); OW = clog2(MAX_OST+1).
REQ-006 SHALL have parameter TO_CYCLES, default 0, idle timeout in cycles (0 = disabled; 32-bit counter).
REQ-007 SHALL have parameter TXN_ID, default 1, value driven on axid.
REQ-008 clk  in  1  sole clock, rising edge.
REQ-009 reset  in  1  synchronous, active-high reset.
REQ-010 cfg_dma_valid/cfg_dma_ready  in/out  1  config handshake.
REQ-011 cfg_dma_sa  in  32  start byte address; cfg_dma_len  in  32  length in bytes.
REQ-012 dma_irq_w1c  in  1  clear DONE; dma_irq  out  1  done; dma_err  out  4  error flags; dma_busy  out  1.
REQ-013 ost_cnt  out  OW  current outstanding burst count.
REQ-014 axid/axaddr/axlen/axsize/axburst/axvalid  out  AXI_IW/AXI_AW/AXI_LW/3/2/1; axready  in  1.
REQ-015 rsp_id  in  AXI_IW; rsp_resp  in  2; rsp_last  in  1 (tie 1 for B channel); rsp_valid, rsp_ready  in  1 (monitor only).

Function
REQ-016 States IDLE, BUSY, RESP, DONE; cfg_dma_ready = (state==IDLE); dma_busy = BUSY|RESP; dma_irq = (state==DONE).
REQ-017 IDLE: on cfg_dma_valid, latch addr_w = cfg_dma_sa[31:L], len_w = cfg_dma_len[31:L] (low L bits ignored); len_w!=0 -> BUSY, len_w==0 -> DONE, no burst issued.
REQ-018 axvalid = (state==BUSY) && (ost_cnt < MAX_OST); axaddr = {addr_w, L zeros} truncated to AXI_AW.
REQ-019 beats = min(BL - (addr_w mod BL), len_w); axlen = beats-1; bursts never cross a BL-beat or 4 KB boundary.
REQ-020 axsize = L, axburst = 2'b01 (INCR), axid = TXN_ID, constant.
REQ-021 axaddr/axlen SHALL stay stable while axvalid=1 and axready=0.
REQ-022 On axvalid&axready: addr_w += beats, len_w -= beats (32-bit wrap on addr allowed, no error).
REQ-023 Response event = rsp_valid&rsp_ready&rsp_last; ost_cnt +1 on AX handshake, -1 on response event, unchanged when both same cycle.
REQ-024 Response event with ost_cnt==0 and no same-cycle AX handshake SHALL be ignored (no underflow).
REQ-025 BUSY: final burst accepted (len_w==beats) -> DONE if next ost_cnt==0, else RESP.
REQ-026 RESP: -> DONE in the cycle next ost_cnt becomes 0.
REQ-027 Timeout (TO_CYCLES>0): counter clears on any AX handshake or response event or outside BUSY/RESP; increments otherwise; on reaching TO_CYCLES set dma_err[3], -> DONE.
REQ-028 dma_err[1:0]: captures rsp_resp of the first non-zero-resp beat (any rsp_valid&rsp_ready); sticky.
REQ-029 dma_err[2]: set on any rsp_valid&rsp_ready with rsp_id != TXN_ID; sticky.
REQ-030 DONE: dma_irq_w1c -> IDLE, same edge clears dma_err[3:0], ost_cnt and timeout counter; w1c outside DONE ignored.

Reset
REQ-031 While reset=1 at clk edge: state IDLE, addr_w/len_w/ost_cnt/timeout=0, dma_err=0; outputs axvalid=0, dma_irq=0, dma_busy=0, cfg_dma_ready=1 in the following cycle.
REQ-032 Reset mid-transfer SHALL abort without further bursts; in-flight responses after reset counted per REQ-024.

Verification
REQ-033 AXI_DW=128, BL=16, sa=0x10, len=0x200, axready=1, resp 1 cycle later -> bursts (0x10,len14),(0x100,len15),(0x200,len0); dma_irq after 3rd response.
REQ-034 MAX_OST=2, responses held off, len=0x400 -> axvalid low after 2 bursts, ost_cnt=2; one response -> 3rd burst issued next cycle.
REQ-035 Second response rsp_resp=2'b10, rsp_id=TXN_ID -> dma_err=4'b0010 in DONE; dma_irq_w1c -> IDLE, dma_err=0.
REQ-036 TO_CYCLES=100, no responses after 1 burst -> dma_err[3]=1 and DONE exactly 100 cycles after last handshake.
REQ-037 len=0x8 (below one beat) -> DONE next cycle, axvalid never asserted; rsp_id=5 on a response -> dma_err[2]=1.
REQ-038 reset=1 while axvalid=1 mid-transfer -> next cycle axvalid=0, state IDLE, ost_cnt=0; new config completes normally.
